check_node_serial: RTL and testbench

CHECK_NODE_SERIAL -- requirements
Module: check_node_serial

---
 rtl/check_node_serial.sv | 127 ++++++++++++
 tb/tb_check_node_serial.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/check_node_serial.sv
// Serial min-sum / offset-min-sum LDPC check node.
// Accumulates one frame of Q messages, then emits one R message per edge in arrival order.
module check_node_serial #(
  parameter int DEG    = 6,
  parameter int PREC   = 4,
  parameter int OFFSET = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_valid,
  input  logic [PREC-1:0] q_data,
  input  logic            q_last,
  output logic            q_ready,
  output logic            r_valid,
  output logic [PREC-1:0] r_data,
  output logic            r_last,
  input  logic            r_ready,
  output logic            deg_err
);

  localparam int MW = PREC - 1;
  localparam int CW = $clog2(DEG + 1);
  localparam logic [MW-1:0] MAX_MAG = '1;
  localparam logic [MW-1:0] OFF     = MW'(OFFSET);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n_len;
  logic [DEG-1:0]  signs;
  logic            sign_prod;
  logic [MW-1:0]   min1;
  logic [MW-1:0]   min2;
  logic [CW-1:0]   min_idx;

  logic            q_fire;
  logic            r_fire;
  logic            frame_end;
  logic            q_sign;
  logic [PREC-1:0] q_neg;
  logic [MW-1:0]   q_mag;
  logic [MW-1:0]   sel_mag;
  logic [MW-1:0]   out_mag;
  logic            out_neg;
  logic [PREC-1:0] out_val;

  assign q_ready = (state == ACCUM);
  assign r_valid = (state == EMIT);

  assign q_fire    = q_valid && (state == ACCUM);
  assign r_fire    = r_ready && (state == EMIT);
  assign frame_end = q_fire && (q_last || (cnt == CW'(DEG - 1)));

  // The most negative input has no positive twin; clamp its magnitude.
  assign q_sign = q_data[PREC-1];
  assign q_neg  = -q_data;
  assign q_mag  = q_sign ? (q_neg[PREC-1] ? MAX_MAG : q_neg[MW-1:0]) : q_data[MW-1:0];

  assign sel_mag = (cnt == min_idx) ? min2 : min1;
  assign out_mag = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
  assign out_neg = signs[cnt] ^ sign_prod;
  assign out_val = out_neg ? -{1'b0, out_mag} : {1'b0, out_mag};

  // R outputs are decoded purely from registered state, so they hold while stalled.
  assign r_data = (state == EMIT) ? out_val : '0;
  assign r_last = (state == EMIT) && (cnt == n_len - CW'(1));

  // NOTE: asynchronous reset is in the sensitivity list so rst takes effect without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      n_len     <= '0;
      signs     <= '0;
      sign_prod <= 1'b0;
      min1      <= MAX_MAG;
      min2      <= MAX_MAG;
      min_idx   <= '0;
      deg_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      deg_err <= 1'b0;
      case (state)
        ACCUM: begin
          if (q_fire) begin
            signs[cnt] <= q_sign;
            sign_prod  <= sign_prod ^ q_sign;
            if (q_mag < min1) begin
              min2    <= min1;
              min1    <= q_mag;
              min_idx <= cnt;
            end else if (q_mag == min1) begin
              min2 <= q_mag;
            end else if (q_mag < min2) begin
              min2 <= q_mag;
            end
            if (frame_end) begin
              n_len   <= cnt + CW'(1);
              cnt     <= '0;
              state   <= EMIT;
              deg_err <= !q_last;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          if (r_fire) begin
            if (r_last) begin
              state     <= ACCUM;
              cnt       <= '0;
              sign_prod <= 1'b0;
              min1      <= MAX_MAG;
              min2      <= MAX_MAG;
              min_idx   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_check_node_serial.sv
// Scoreboard bench for check_node_serial: instance 0 uses OFFSET=0, instance 1 uses OFFSET=1.
module tb_check_node_serial;

  logic clk = 1'b0;
  logic rst;
  logic             q_valid [2];
  logic [3:0]       q_data  [2];
  logic             q_last  [2];
  logic             q_ready [2];
  logic             r_valid [2];
  logic [3:0]       r_data  [2];
  logic             r_last  [2];
  logic             r_ready [2];
  logic             deg_err [2];

  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q [2][$];
  int   checks = 0;
  int   errors = 0;
  int   pops    [2];
  bit   stalled [2];
  logic [3:0] held_data [2];
  logic       held_last [2];
  bit   stall_en = 0;
  int   stall_ph = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    check_node_serial #(.DEG(6), .PREC(4), .OFFSET(g)) dut (
      .clk    (clk),
      .rst    (rst),
      .q_valid(q_valid[g]),
      .q_data (q_data[g]),
      .q_last (q_last[g]),
      .q_ready(q_ready[g]),
      .r_valid(r_valid[g]),
      .r_data (r_data[g]),
      .r_last (r_last[g]),
      .r_ready(r_ready[g]),
      .deg_err(deg_err[g])
    );
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops and compares on every R transfer, and checks holding while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (r_valid[i]) begin
          check(q_ready[i] == 1'b0, "q_ready_in_emit", int'(q_ready[i]), 0);
          if (stalled[i]) begin
            check(r_data[i] == held_data[i], "stall_data", int'($signed(r_data[i])), int'($signed(held_data[i])));
            check(r_last[i] == held_last[i], "stall_last", int'(r_last[i]), int'(held_last[i]));
          end
          if (r_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              check(1'b0, "unexpected_r", int'($signed(r_data[i])), 0);
            end else begin
              exp_t e;
              e = exp_q[i].pop_front();
              check(r_data[i] == e.data, "r_data", int'($signed(r_data[i])), int'($signed(e.data)));
              check(r_last[i] == e.last, "r_last", int'(r_last[i]), int'(e.last));
            end
            pops[i]++;
          end
          stalled[i]   = !r_ready[i];
          held_data[i] = r_data[i];
          held_last[i] = r_last[i];
        end else begin
          stalled[i] = 0;
        end
      end
    end
  end

  // r_ready pattern 1,0,0 repeating while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_en) begin
        r_ready[0] = (stall_ph % 3 == 0);
        stall_ph++;
      end
    end
  end

  task automatic push_exp(input int i, input int n, input int rv[8]);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.data = 4'(rv[k]);
      e.last = (k == n - 1);
      exp_q[i].push_back(e);
    end
  endtask

  task automatic send_frame(input int i, input int n, input int qv[8], input bit use_last,
                            input bit exp_deg);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      q_valid[i] = 1'b1;
      q_data[i]  = 4'(qv[k]);
      q_last[i]  = use_last && (k == n - 1);
      while (!q_ready[i] && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check(q_ready[i] == 1'b1, "q_ready_wait", int'(q_ready[i]), 1);
      check(r_valid[i] == 1'b0, "r_valid_early", int'(r_valid[i]), 0);
      @(posedge clk); #1;
    end
    q_valid[i] = 1'b0;
    q_last[i]  = 1'b0;
    check(r_valid[i] == 1'b1, "r_valid_latency", int'(r_valid[i]), 1);
    check(deg_err[i] == exp_deg, "deg_err", int'(deg_err[i]), int'(exp_deg));
    @(posedge clk); #1;
    check(deg_err[i] == 1'b0, "deg_err_pulse", int'(deg_err[i]), 0);
  endtask

  task automatic drain(input int i);
    int t = 0;
    while (exp_q[i].size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check(exp_q[i].size() == 0, "drain_timeout", exp_q[i].size(), 0);
    @(posedge clk); #1;
    check(q_ready[i] == 1'b1, "q_ready_after", int'(q_ready[i]), 1);
    check(r_valid[i] == 1'b0, "r_valid_after", int'(r_valid[i]), 0);
  endtask

  task automatic run(input int i, input int n, input int qv[8], input int rv[8],
                     input bit use_last, input bit exp_deg);
    push_exp(i, n, rv);
    send_frame(i, n, qv, use_last, exp_deg);
    drain(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int basic_q[8] = '{3, -2, 5, -1, 4, 6, 0, 0};
    int basic_r[8] = '{1, -1, 1, -2, 1, 1, 0, 0};
    int t;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_valid[i] = 1'b0; q_data[i] = '0; q_last[i] = 1'b0; r_ready[i] = 1'b1;
      pops[i] = 0; stalled[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check(q_ready[i] == 1'b1, "reset_q_ready", int'(q_ready[i]), 1);
      check(r_valid[i] == 1'b0, "reset_r_valid", int'(r_valid[i]), 0);
      check(r_data[i] == 4'd0, "reset_r_data", int'(r_data[i]), 0);
      check(r_last[i] == 1'b0, "reset_r_last", int'(r_last[i]), 0);
      check(deg_err[i] == 1'b0, "reset_deg_err", int'(deg_err[i]), 0);
    end
    rst = 1'b0;

    // Basic frame: min1=1 at edge 3, min2=2, sign product 0.
    run(0, 6, basic_q, basic_r, 1'b1, 1'b0);
    // Saturation and ties: magnitudes 7,7,2; min1=2 at edge 2, min2=7; sign product 0.
    run(0, 3, '{-8, -7, 2, 0, 0, 0, 0, 0}, '{-2, -2, 7, 0, 0, 0, 0, 0}, 1'b1, 1'b0);
    // Backpressure on the basic frame.
    stall_en = 1; stall_ph = 0;
    run(0, 6, basic_q, basic_r, 1'b1, 1'b0);
    stall_en = 0; r_ready[0] = 1'b1;
    // Degree overflow: six edges without q_last.
    run(0, 6, basic_q, basic_r, 1'b0, 1'b1);
    // Single-edge frame: min2 stays at 7, sign s^s = 0.
    run(0, 1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{7, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0);
    // Offset 1: mags 1,3,4, sign product 1 -> edge0 -(3-1), edges 1,2 floor to 0.
    run(1, 3, '{1, -3, 4, 0, 0, 0, 0, 0}, '{-2, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0);
    run(1, 1, '{-5, 0, 0, 0, 0, 0, 0, 0}, '{6, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0);

    // Reset in the middle of EMIT after the second R.
    pops[0] = 0;
    push_exp(0, 6, basic_r);
    send_frame(0, 6, basic_q, 1'b1, 1'b0);
    t = 0;
    while (pops[0] < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check(pops[0] >= 2, "mid_emit_wait", pops[0], 2);
    rst = 1'b1;
    #1;
    check(r_valid[0] == 1'b0, "rst_r_valid", int'(r_valid[0]), 0);
    check(q_ready[0] == 1'b1, "rst_q_ready", int'(q_ready[0]), 1);
    check(r_data[0] == 4'd0, "rst_r_data", int'(r_data[0]), 0);
    exp_q[0].delete();
    stalled[0] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    // Fresh frame after reset: mags 2,5, sign product 1 -> -5, +2.
    run(0, 2, '{2, -5, 0, 0, 0, 0, 0, 0}, '{-5, 2, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
